cam_match_resolver: RTL and testbench

Sequential multi-match resolver on the consumer side of the CAM search path. Captures a DEPTH-bit match vector and streams out the address of every set bit, lowest index first, one per accepted handshake. Downstream logic (read-back, delete, update) receives plain addresses instead of one-hot or multi-hot vectors. Sits between the CAM match output and any address-indexed consumer.

---
 rtl/cam_pkg.sv | 29 ++
 rtl/cam_match_resolver_if.sv | 33 +++
 rtl/cam_prio_enc.sv | 28 ++
 rtl/cam_match_resolver.sv | 95 +++++++++
 tb/tb_cam_match_resolver.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/cam_pkg.sv
// Shared CAM definitions: resolver state encoding, default CAM depth and the
// constant/helper functions used by both the CAM and its match resolver.
package cam_pkg;

  localparam int CAM_DEPTH = 16;

  // Widest match vector popcount() accepts; callers zero-extend to this width.
  localparam int MAX_DEPTH = 256;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } res_state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  function automatic int unsigned popcount(input logic [MAX_DEPTH-1:0] vec);
    int unsigned n;
    n = 0;
    for (int i = 0; i < MAX_DEPTH; i++) n += int'(vec[i]);
    return n;
  endfunction

endpackage

// File: rtl/cam_match_resolver_if.sv
// Resolver-facing bundle: match vector capture controls plus the outgoing
// address stream with its ready/valid handshake and status flags.
interface cam_match_resolver_if
  import cam_pkg::*;
#(
  parameter int DEPTH  = CAM_DEPTH,
  parameter int ADDR_W = clog2(DEPTH)
);

  logic [DEPTH-1:0]  match_in;
  logic              load;
  logic              flush;
  logic              busy;
  logic              idx_valid;
  logic              idx_ready;
  logic [ADDR_W-1:0] idx;
  logic              idx_last;
  logic [ADDR_W:0]   count;
  logic              no_match;

  // The resolver produces the address stream.
  modport master (
    input  match_in, load, flush, idx_ready,
    output busy, idx_valid, idx, idx_last, count, no_match
  );

  // The CAM / consumer side that feeds vectors and accepts addresses.
  modport slave (
    output match_in, load, flush, idx_ready,
    input  busy, idx_valid, idx, idx_last, count, no_match
  );

endinterface

// File: rtl/cam_prio_enc.sv
// Combinational lowest-set-bit encoder: returns the index of the lowest set
// bit, whether any bit is set, and whether exactly one bit is set.
module cam_prio_enc
  import cam_pkg::*;
#(
  parameter int DEPTH  = CAM_DEPTH,
  parameter int ADDR_W = clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]  vec,
  output logic [ADDR_W-1:0] idx,
  output logic              any,
  output logic              onehot
);

  // NOTE: every variable written here gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    idx = '0;
    // Scanning downward lets the lowest set bit be the last one written.
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (vec[i]) idx = ADDR_W'(i);
    end
  end

  assign any    = |vec;
  assign onehot = any && ((vec & (vec - DEPTH'(1))) == '0);

endmodule

// File: rtl/cam_match_resolver.sv
// Multi-match resolver: captures a CAM match vector and streams the address
// of each set bit, lowest first, one per accepted idx handshake.
module cam_match_resolver
  import cam_pkg::*;
#(
  parameter int DEPTH  = CAM_DEPTH,
  parameter int ADDR_W = clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  cam_match_resolver_if.master bus
);

  localparam int CNT_W = ADDR_W + 1;

  res_state_t        state, state_nxt;
  logic [DEPTH-1:0]  pending, pending_nxt;
  logic [CNT_W-1:0]  count, count_nxt;
  logic              no_match, no_match_nxt;

  logic [ADDR_W-1:0] enc_idx;
  logic              enc_any;
  logic              enc_onehot;
  logic              emitting;
  logic              handshake;

  cam_prio_enc #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_prio_enc (
    .vec    (pending),
    .idx    (enc_idx),
    .any    (enc_any),
    .onehot (enc_onehot)
  );

  assign emitting  = (state == EMIT);
  assign handshake = emitting && enc_any && bus.idx_ready;

  always_comb begin
    state_nxt    = state;
    pending_nxt  = pending;
    count_nxt    = count;
    no_match_nxt = 1'b0;

    if (bus.flush) begin
      // Flush outranks both load and handshake; count is kept for reporting.
      state_nxt   = IDLE;
      pending_nxt = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.load) begin
            pending_nxt = bus.match_in;
            count_nxt   = CNT_W'(popcount(MAX_DEPTH'(bus.match_in)));
            if (bus.match_in == '0) no_match_nxt = 1'b1;
            else                    state_nxt    = EMIT;
          end
        end
        EMIT: begin
          if (handshake) begin
            pending_nxt[enc_idx] = 1'b0;
            if (enc_onehot) state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      pending  <= '0;
      count    <= '0;
      no_match <= 1'b0;
    end else begin
      state    <= state_nxt;
      pending  <= pending_nxt;
      count    <= count_nxt;
      no_match <= no_match_nxt;
    end
  end

  // Outputs are decoded from registered state only; pending is zero in IDLE.
  assign bus.busy      = emitting;
  assign bus.idx_valid = emitting && enc_any;
  assign bus.idx       = enc_idx;
  assign bus.idx_last  = emitting && enc_onehot;
  assign bus.count     = count;
  assign bus.no_match  = no_match;

endmodule

// File: tb/tb_cam_match_resolver.sv
// Self-checking bench for cam_match_resolver: queue-based reference model
// compared every cycle, plus directed literal expectations per scenario.
module tb_cam_match_resolver;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  cam_match_resolver_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) bus ();

  cam_match_resolver #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the remaining addresses of the captured vector as a queue.
  int unsigned exp_q[$];
  int unsigned m_count    = 0;
  bit          m_no_match = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
      m_count    = 0;
      m_no_match = 1'b0;
    end else begin
      m_no_match = 1'b0;
      if (bus.flush) begin
        exp_q.delete();
      end else if (exp_q.size() == 0) begin
        if (bus.load) begin
          for (int b = 0; b < DEPTH; b++)
            if (bus.match_in[b]) exp_q.push_back(b);
          m_count = exp_q.size();
          if (m_count == 0) m_no_match = 1'b1;
        end
      end else if (bus.idx_ready) begin
        void'(exp_q.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("busy",      32'(bus.busy),      32'(exp_q.size() != 0));
      check("idx_valid", 32'(bus.idx_valid), 32'(exp_q.size() != 0));
      check("idx",       32'(bus.idx),       (exp_q.size() != 0) ? exp_q[0] : 0);
      check("idx_last",  32'(bus.idx_last),  32'(exp_q.size() == 1));
      check("count",     32'(bus.count),     m_count);
      check("no_match",  32'(bus.no_match),  32'(m_no_match));
    end
  end

  task automatic do_load(input logic [DEPTH-1:0] v);
    bus.load     = 1'b1;
    bus.match_in = v;
    @(negedge clk);
    bus.load     = 1'b0;
    bus.match_in = '0;
  endtask

  initial begin
    bus.match_in  = '0;
    bus.load      = 1'b0;
    bus.flush     = 1'b0;
    bus.idx_ready = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_busy",  32'(bus.busy),      0);
    check("rst_valid", 32'(bus.idx_valid), 0);
    check("rst_count", 32'(bus.count),     0);
    check("rst_idx",   32'(bus.idx),       0);
    rst = 1'b0;
    @(negedge clk);

    // 1. Empty vector
    do_load(16'h0000);
    check("t1_no_match", 32'(bus.no_match),  1);
    check("t1_valid",    32'(bus.idx_valid), 0);
    check("t1_busy",     32'(bus.busy),      0);
    check("t1_count",    32'(bus.count),     0);
    @(negedge clk);
    check("t1_pulse_end", 32'(bus.no_match), 0);

    // 2. Sparse vector, ready held high
    do_load(16'h8421);
    check("t2_count", 32'(bus.count), 4);
    for (int k = 0; k < 4; k++) begin
      check("t2_idx",  32'(bus.idx),       32'(k * 5));
      check("t2_last", 32'(bus.idx_last),  32'(k == 3));
      check("t2_vld",  32'(bus.idx_valid), 1);
      @(negedge clk);
    end
    check("t2_busy_end", 32'(bus.busy), 0);

    // 3. Backpressure
    bus.idx_ready = 1'b0;
    do_load(16'h0006);
    for (int k = 0; k < 3; k++) begin
      check("t3_hold_idx",  32'(bus.idx),       1);
      check("t3_hold_vld",  32'(bus.idx_valid), 1);
      check("t3_hold_last", 32'(bus.idx_last),  0);
      @(negedge clk);
    end
    bus.idx_ready = 1'b1;
    check("t3_idx1", 32'(bus.idx), 1);
    @(negedge clk);
    check("t3_idx2",  32'(bus.idx),      2);
    check("t3_last2", 32'(bus.idx_last), 1);
    @(negedge clk);
    check("t3_busy_end", 32'(bus.busy), 0);

    // 4. Full vector
    do_load(16'hFFFF);
    check("t4_count", 32'(bus.count), 16);
    for (int k = 0; k < 16; k++) begin
      check("t4_idx",  32'(bus.idx),      32'(k));
      check("t4_last", 32'(bus.idx_last), 32'(k == 15));
      @(negedge clk);
    end
    check("t4_busy_end", 32'(bus.busy), 0);

    // 5. Load while busy is ignored; flush aborts and drops a same-cycle load
    do_load(16'h00F0);
    bus.load     = 1'b1;
    bus.match_in = 16'h0001;
    check("t5_idx4", 32'(bus.idx), 4);
    @(negedge clk);
    check("t5_idx5", 32'(bus.idx), 5);
    @(negedge clk);
    check("t5_idx6", 32'(bus.idx), 6);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush    = 1'b0;
    bus.load     = 1'b0;
    bus.match_in = '0;
    check("t5_flush_vld",   32'(bus.idx_valid), 0);
    check("t5_flush_busy",  32'(bus.busy),      0);
    check("t5_flush_count", 32'(bus.count),     4);
    do_load(16'h0001);
    check("t5_new_idx",   32'(bus.idx),      0);
    check("t5_new_last",  32'(bus.idx_last), 1);
    check("t5_new_count", 32'(bus.count),    1);
    @(negedge clk);
    check("t5_new_done", 32'(bus.busy), 0);
    // Flush in IDLE with a simultaneous load: the load is dropped.
    bus.flush    = 1'b1;
    bus.load     = 1'b1;
    bus.match_in = 16'h0003;
    @(negedge clk);
    bus.flush    = 1'b0;
    bus.load     = 1'b0;
    bus.match_in = '0;
    check("t5_idle_flush_busy",  32'(bus.busy),  0);
    check("t5_idle_flush_count", 32'(bus.count), 1);

    // 6. Asynchronous reset mid-stream
    do_load(16'h0300);
    check("t6_idx8", 32'(bus.idx), 8);
    @(negedge clk);
    check("t6_idx9", 32'(bus.idx), 9);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_vld",   32'(bus.idx_valid), 0);
    check("t6_rst_busy",  32'(bus.busy),      0);
    check("t6_rst_idx",   32'(bus.idx),       0);
    check("t6_rst_last",  32'(bus.idx_last),  0);
    check("t6_rst_count", 32'(bus.count),     0);
    check("t6_rst_nm",    32'(bus.no_match),  0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t6_no_idx9", 32'(bus.idx_valid), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
